// File: rtl/cmd_frame_parser.sv
// Byte-stream command framer: HEADER, OPCODE, LEN, payload, XOR checksum.
// Good frames pulse cmd_valid/start_count; malformed, stalled or corrupt frames pulse an error.
module cmd_frame_parser #(
  parameter logic [7:0] HEADER       = 8'hA5,
  parameter int         MAX_LEN      = 16,
  parameter int         BYTE_TIMEOUT = 255
) (
  input  logic        sys_clk,
  input  logic        sys_resetb,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        cmd_valid,
  output logic [7:0]  cmd_opcode,
  output logic [7:0]  cmd_len,
  output logic        pl_we,
  output logic [7:0]  pl_addr,
  output logic [7:0]  pl_data,
  output logic        start_count,
  output logic        fmt_err,
  output logic        crc_err,
  output logic [15:0] frame_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_OPC  = 3'd1;
  localparam logic [2:0] S_LEN  = 3'd2;
  localparam logic [2:0] S_PAY  = 3'd3;
  localparam logic [2:0] S_CHK  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [7:0]  MAX_LEN_B = MAX_LEN[7:0];
  localparam logic [15:0] TO_LAST   = 16'(BYTE_TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  opc_q, opc_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  chk_q, chk_d;
  logic [15:0] timer_q, timer_d;
  logic        fmt_q, fmt_d;
  logic        crc_q, crc_d;
  logic [7:0]  cmd_opcode_q, cmd_opcode_d;
  logic [7:0]  cmd_len_q, cmd_len_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        accept;
  logic        in_frame;

  assign accept   = rx_valid && rx_ready;
  assign in_frame = (state_q == S_OPC) || (state_q == S_LEN) ||
                    (state_q == S_PAY) || (state_q == S_CHK);

  always_comb begin
    state_d      = state_q;
    opc_d        = opc_q;
    len_d        = len_q;
    idx_d        = idx_q;
    chk_d        = chk_q;
    timer_d      = 16'd0;
    fmt_d        = 1'b0;
    crc_d        = 1'b0;
    cmd_opcode_d = cmd_opcode_q;
    cmd_len_d    = cmd_len_q;
    frame_cnt_d  = frame_cnt_q;

    case (state_q)
      S_IDLE: if (accept && rx_data == HEADER) state_d = S_OPC;
      S_OPC: if (accept) begin
        opc_d   = rx_data;
        chk_d   = rx_data;
        state_d = S_LEN;
      end
      S_LEN: if (accept) begin
        len_d = rx_data;
        chk_d = chk_q ^ rx_data;
        if (rx_data > MAX_LEN_B) begin
          fmt_d   = 1'b1;
          state_d = S_IDLE;
        end else if (rx_data == 8'd0) begin
          state_d = S_CHK;
        end else begin
          idx_d   = 8'd0;
          state_d = S_PAY;
        end
      end
      S_PAY: if (accept) begin
        chk_d = chk_q ^ rx_data;
        idx_d = idx_q + 8'd1;
        if (idx_q == len_q - 8'd1) state_d = S_CHK;
      end
      S_CHK: if (accept) begin
        if (rx_data == chk_q) begin
          state_d      = S_DONE;
          cmd_opcode_d = opc_q;
          cmd_len_d    = len_q;
          if (frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
          crc_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // An accepted byte always beats the timeout; the counter only runs while stalled mid-frame.
    if (in_frame && !accept) begin
      if (timer_q == TO_LAST) begin
        fmt_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        timer_d = timer_q + 16'd1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_resetb) begin
    if (!sys_resetb) begin
      state_q      <= S_IDLE;
      opc_q        <= 8'd0;
      len_q        <= 8'd0;
      idx_q        <= 8'd0;
      chk_q        <= 8'd0;
      timer_q      <= 16'd0;
      fmt_q        <= 1'b0;
      crc_q        <= 1'b0;
      cmd_opcode_q <= 8'd0;
      cmd_len_q    <= 8'd0;
      frame_cnt_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      opc_q        <= opc_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      chk_q        <= chk_d;
      timer_q      <= timer_d;
      fmt_q        <= fmt_d;
      crc_q        <= crc_d;
      cmd_opcode_q <= cmd_opcode_d;
      cmd_len_q    <= cmd_len_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  // Ready is forced low while reset is held so every output reads 0 during reset.
  assign rx_ready    = sys_resetb && (state_q != S_DONE);
  assign cmd_valid   = (state_q == S_DONE);
  assign start_count = (state_q == S_DONE);
  assign pl_we       = (state_q == S_PAY) && rx_valid;
  assign pl_addr     = pl_we ? idx_q : 8'd0;
  assign pl_data     = pl_we ? rx_data : 8'd0;
  assign fmt_err     = fmt_q;
  assign crc_err     = crc_q;
  assign cmd_opcode  = cmd_opcode_q;
  assign cmd_len     = cmd_len_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Bench for cmd_frame_parser: directed frames plus random frames checked against a frame-level model.
module tb_cmd_frame_parser;

  localparam logic [7:0] HDR  = 8'hA5;
  localparam int         MAXL = 16;
  localparam int         TO   = 255;

  logic        sys_clk = 1'b0;
  logic        sys_resetb = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_ready;
  logic        cmd_valid;
  logic [7:0]  cmd_opcode;
  logic [7:0]  cmd_len;
  logic        pl_we;
  logic [7:0]  pl_addr;
  logic [7:0]  pl_data;
  logic        start_count;
  logic        fmt_err;
  logic        crc_err;
  logic [15:0] frame_cnt;

  always #5 sys_clk = ~sys_clk;

  cmd_frame_parser dut (
    .sys_clk(sys_clk), .sys_resetb(sys_resetb),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .cmd_valid(cmd_valid), .cmd_opcode(cmd_opcode), .cmd_len(cmd_len),
    .pl_we(pl_we), .pl_addr(pl_addr), .pl_data(pl_data),
    .start_count(start_count), .fmt_err(fmt_err), .crc_err(crc_err),
    .frame_cnt(frame_cnt)
  );

  int n_assert = 0;
  int n_fail = 0;
  int exp_fcnt = 0;
  logic [7:0] pay [0:255];

  // Output monitor, sampled on the falling edge.
  int cyc = 0, last_acc = 0;
  int n_cmd = 0, n_start = 0, n_fmt = 0, n_crc = 0, n_viol = 0;
  int cmd_gap = 0, err_gap = 0;
  logic [7:0] wa [$];
  logic [7:0] wd [$];

  always @(negedge sys_clk) begin
    cyc <= cyc + 1;
    if (sys_resetb) begin
      if (pl_we) begin
        wa.push_back(pl_addr);
        wd.push_back(pl_data);
      end
      if (cmd_valid) begin
        n_cmd   <= n_cmd + 1;
        cmd_gap <= cyc - last_acc;
      end
      if (start_count) n_start <= n_start + 1;
      if (fmt_err) begin
        n_fmt   <= n_fmt + 1;
        err_gap <= cyc - last_acc;
      end
      if (crc_err) begin
        n_crc   <= n_crc + 1;
        err_gap <= cyc - last_acc;
      end
      if ((int'(cmd_valid) + int'(fmt_err) + int'(crc_err) > 1) || (start_count !== cmd_valid))
        n_viol <= n_viol + 1;
      if (rx_valid && rx_ready) last_acc <= cyc;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge sys_clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // kind: 0 good, 1 bad checksum, 2 length too big, 3 stall after stall_at bytes past the header.
  // long_pos: index of the byte preceded by TO-1 idle cycles (arrives on the last allowed cycle).
  task automatic do_frame(input int kind, input logic [7:0] opc, input int len,
                          input int stall_at, input int gap_max, input logic [7:0] flip,
                          input int long_pos, input bit noise);
    logic [7:0] q [$];
    logic [7:0] ck;
    int b_cmd, b_start, b_fmt, b_crc, b_wr, b_viol, n_send, exp_wr;
    b_cmd = n_cmd; b_start = n_start; b_fmt = n_fmt; b_crc = n_crc;
    b_wr = wa.size(); b_viol = n_viol;

    ck = opc ^ len[7:0];
    q.push_back(HDR); q.push_back(opc); q.push_back(len[7:0]);
    if (kind == 2) begin
      q.push_back(8'h00); q.push_back(8'h00);
    end else begin
      for (int i = 0; i < len; i++) begin
        q.push_back(pay[i]);
        ck = ck ^ pay[i];
      end
      q.push_back(ck ^ flip);
    end
    n_send = (kind == 3) ? 1 + stall_at : q.size();
    if (kind == 0 || kind == 1) exp_wr = len;
    else if (kind == 2) exp_wr = 0;
    else begin
      exp_wr = n_send - 3;
      if (exp_wr < 0) exp_wr = 0;
      if (exp_wr > len) exp_wr = len;
    end

    if (noise) begin
      logic [7:0] nb;
      nb = 8'($urandom_range(255));
      if (nb == HDR) nb = 8'h00;
      send_byte(nb);
    end
    for (int i = 0; i < n_send; i++) begin
      if (i == long_pos) idle(TO - 1);
      else if (i > 0 && gap_max > 0) idle($urandom_range(gap_max));
      send_byte(q[i]);
    end
    idle((kind == 3) ? TO + 8 : 6);

    if (kind == 0) exp_fcnt = (exp_fcnt == 65535) ? 65535 : exp_fcnt + 1;
    chk("pl_we_count", wa.size() - b_wr, exp_wr);
    for (int k = 0; k < exp_wr && (b_wr + k) < wa.size(); k++) begin
      chk("pl_addr", int'(wa[b_wr + k]), k);
      chk("pl_data", int'(wd[b_wr + k]), int'(pay[k]));
    end
    chk("cmd_valid_count", n_cmd - b_cmd, (kind == 0) ? 1 : 0);
    chk("start_count_count", n_start - b_start, (kind == 0) ? 1 : 0);
    chk("fmt_err_count", n_fmt - b_fmt, (kind == 2 || kind == 3) ? 1 : 0);
    chk("crc_err_count", n_crc - b_crc, (kind == 1) ? 1 : 0);
    chk("exclusive_pulses", n_viol - b_viol, 0);
    chk("frame_cnt", int'(frame_cnt), exp_fcnt);
    if (kind == 0) begin
      chk("cmd_opcode", int'(cmd_opcode), int'(opc));
      chk("cmd_len", int'(cmd_len), len);
      chk("cmd_latency", cmd_gap, 1);
    end else if (kind == 3) begin
      chk("timeout_latency", err_gap, TO + 1);
    end else begin
      chk("err_latency", err_gap, 1);
    end
    $display("frame kind=%0d opc=%02h len=%0d stall=%0d long=%0d writes=%0d frame_cnt=%0d",
             kind, opc, len, stall_at, long_pos, wa.size() - b_wr, frame_cnt);
  endtask

  initial begin
    // Reset state
    #2;
    @(negedge sys_clk);
    chk("rst_rx_ready", int'(rx_ready), 0);
    chk("rst_cmd_valid", int'(cmd_valid), 0);
    chk("rst_start_count", int'(start_count), 0);
    chk("rst_errs", int'({fmt_err, crc_err, pl_we}), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    chk("rst_cmd", int'({cmd_opcode, cmd_len}), 0);
    sys_resetb = 1'b1;
    idle(2);
    chk("idle_rx_ready", int'(rx_ready), 1);

    pay[0] = 8'h11; pay[1] = 8'h22;
    do_frame(0, 8'h10, 2, 0, 0, 8'h00, -1, 1'b0);
    do_frame(1, 8'h10, 2, 0, 0, 8'h01, -1, 1'b0);
    do_frame(2, 8'h33, 17, 0, 0, 8'h00, -1, 1'b0);
    do_frame(3, 8'h44, 2, 1, 0, 8'h00, -1, 1'b0);
    do_frame(0, 8'h44, 2, 0, 0, 8'h00, 2, 1'b0);
    do_frame(0, 8'h7E, 0, 0, 0, 8'h00, -1, 1'b0);
    for (int i = 0; i < MAXL; i++) pay[i] = 8'(i * 37 + 5);
    pay[3] = HDR;
    do_frame(0, 8'hC3, MAXL, 0, 1, 8'h00, 5, 1'b1);
    do_frame(2, 8'h01, 255, 0, 0, 8'h00, -1, 1'b0);

    // Reset in the middle of a payload: partial frame dropped silently
    pay[0] = 8'h9A; pay[1] = 8'hBC; pay[2] = 8'hDE; pay[3] = 8'hF0;
    begin
      int b_fmt, b_crc, b_cmd;
      send_byte(HDR); send_byte(8'h55); send_byte(8'h04);
      send_byte(pay[0]); send_byte(pay[1]);
      sys_resetb = 1'b0;
      @(negedge sys_clk);
      chk("midrst_pl_we", int'(pl_we), 0);
      chk("midrst_rx_ready", int'(rx_ready), 0);
      chk("midrst_frame_cnt", int'(frame_cnt), 0);
      idle(2);
      sys_resetb = 1'b1;
      exp_fcnt = 0;
      b_fmt = n_fmt; b_crc = n_crc; b_cmd = n_cmd;
      idle(TO + 5);
      chk("midrst_no_err", (n_fmt - b_fmt) + (n_crc - b_crc) + (n_cmd - b_cmd), 0);
      $display("reset mid-payload, quiet window checked");
    end
    do_frame(0, 8'h55, 4, 0, 0, 8'h00, -1, 1'b0);

    // Random frames
    for (int f = 0; f < 40; f++) begin
      int kind, len, stall;
      logic [7:0] flip, opc;
      kind = $urandom_range(3);
      len  = (kind == 2) ? $urandom_range(255, MAXL + 1) : $urandom_range(MAXL, 0);
      flip = (kind == 1) ? 8'($urandom_range(255, 1)) : 8'h00;
      stall = (kind == 3) ? $urandom_range(len + 2, 1) : 0;
      opc  = 8'($urandom_range(255));
      for (int i = 0; i < len && i < 256; i++) pay[i] = 8'($urandom_range(255));
      do_frame(kind, opc, len, stall, 3, flip, -1, 1'($urandom_range(1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "time limit");
  end

endmodule
